// File: rtl/pressure_pkg.sv
// Shared definitions for the pressure-sensor slider front end.
package pressure_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 120000;
    localparam int N_CH_DEF            = 3;
    localparam int CNT_W_DEF           = 32;

    // Per-channel debounce state: settled, or a different level is being timed.
    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } ch_state_e;

endpackage

// File: rtl/slider_debounce_ch.sv
// One slider channel: 2-FF synchroniser, debounce FSM with hold counter,
// debounced level register and registered rise/fall pulses.
module slider_debounce_ch
    import pressure_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_reg;
    logic            sync2_reg;
    ch_state_e       state_reg, state_next;
    logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
    logic            clean_reg, clean_next;
    logic            rise_reg, rise_next;
    logic            fall_reg, fall_next;

    // Two-stage synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // FSM, hold counter, debounced level and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= STABLE;
            db_cnt_reg <= '0;
            clean_reg  <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            db_cnt_reg <= db_cnt_next;
            clean_reg  <= clean_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
        end
    end

    // Next-state: time how long the synchronised level differs from the
    // accepted one; a return to the accepted level cancels the change.
    always_comb begin
        state_next  = state_reg;
        db_cnt_next = db_cnt_reg;
        clean_next  = clean_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        case (state_reg)
            STABLE: begin
                db_cnt_next = '0;
                if (sync2_reg != clean_reg) begin
                    state_next  = PENDING;
                    db_cnt_next = DB_W'(1);
                end
            end
            PENDING: begin
                if (sync2_reg == clean_reg) begin
                    state_next  = STABLE;
                    db_cnt_next = '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    clean_next  = sync2_reg;
                    rise_next   = sync2_reg;
                    fall_next   = ~sync2_reg;
                    state_next  = STABLE;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt_reg + DB_W'(1);
                end
            end
            default: begin
                state_next  = STABLE;
                db_cnt_next = '0;
            end
        endcase
    end

    assign clean = clean_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/slider_conditioner.sv
// Slider front end: per-channel debounce, channel-0 press counter and a
// popcount of currently active sliders.
module slider_conditioner
    import pressure_pkg::*;
#(
    parameter int N_CH            = N_CH_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CH-1:0]            slider_raw,
    input  logic                       clr_cnt,
    output logic [N_CH-1:0]            slider_clean,
    output logic [N_CH-1:0]            rise_pulse,
    output logic [N_CH-1:0]            fall_pulse,
    output logic [CNT_W-1:0]           press_cnt,
    output logic [$clog2(N_CH+1)-1:0]  active_cnt
);

    localparam int ACT_W = $clog2(N_CH + 1);

    logic [CNT_W-1:0] press_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            slider_debounce_ch #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_ch (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (slider_raw[gi]),
                .clean(slider_clean[gi]),
                .rise (rise_pulse[gi]),
                .fall (fall_pulse[gi])
            );
        end
    endgenerate

    // Press counter follows the registered rise pulse; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_cnt_reg <= '0;
        end else if (clr_cnt) begin
            press_cnt_reg <= '0;
        end else if (rise_pulse[0]) begin
            press_cnt_reg <= press_cnt_reg + CNT_W'(1);
        end
    end

    // Popcount of the registered clean levels, so it cannot glitch.
    always_comb begin
        active_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            active_cnt = active_cnt + ACT_W'(slider_clean[i]);
        end
    end

    assign press_cnt = press_cnt_reg;

endmodule

// File: tb/tb_slider_conditioner.sv
// Bench for slider_conditioner: directed scenarios plus random pin activity,
// every cycle compared against a run-length reference model.
module tb_slider_conditioner;

    localparam int N_CH  = 3;
    localparam int DB    = 4;
    localparam int CNT_W = 4;
    localparam int ACT_W = $clog2(N_CH + 1);

    logic               clk;
    logic               rst_n;
    logic [N_CH-1:0]    slider_raw;
    logic               clr_cnt;
    logic [N_CH-1:0]    slider_clean;
    logic [N_CH-1:0]    rise_pulse;
    logic [N_CH-1:0]    fall_pulse;
    logic [CNT_W-1:0]   press_cnt;
    logic [ACT_W-1:0]   active_cnt;

    int tests_run;
    int tests_failed;

    // Reference model state
    logic [N_CH-1:0]  sync_q[$];
    logic [N_CH-1:0]  m_clean, m_rise, m_fall;
    logic [CNT_W-1:0] m_press;
    int               m_run[N_CH];

    slider_conditioner #(
        .N_CH(N_CH),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .slider_raw  (slider_raw),
        .clr_cnt     (clr_cnt),
        .slider_clean(slider_clean),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .press_cnt   (press_cnt),
        .active_cnt  (active_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sync_q.delete();
        sync_q.push_back('0);
        sync_q.push_back('0);
        m_clean = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_press = '0;
        for (int i = 0; i < N_CH; i++) m_run[i] = 0;
    endtask

    // A channel accepts a new level once the synchronised pin (raw delayed by
    // two edges) has disagreed with the accepted level for DB consecutive edges.
    task automatic model_edge();
        logic [N_CH-1:0] s;
        if (!rst_n) begin
            model_reset();
        end else begin
            s = sync_q.pop_front();
            sync_q.push_back(slider_raw);
            if (clr_cnt)        m_press = '0;
            else if (m_rise[0]) m_press = m_press + 1'b1;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N_CH; i++) begin
                if (s[i] != m_clean[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_clean[i] = s[i];
                        m_rise[i]  = s[i];
                        m_fall[i]  = ~s[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_val("clean",  32'(slider_clean), 32'(m_clean));
        check_val("rise",   32'(rise_pulse),   32'(m_rise));
        check_val("fall",   32'(fall_pulse),   32'(m_fall));
        check_val("press",  32'(press_cnt),    32'(m_press));
        check_val("active", 32'(active_cnt),   32'($countones(m_clean)));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    int rises;
    int rise_at;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_reset();

        // Reset with pins high: everything held at zero.
        rst_n      = 1'b0;
        slider_raw = 3'b111;
        clr_cnt    = 1'b0;
        #23;
        compare_all();
        check_val("rst_clean", 32'(slider_clean), 32'd0);
        step();
        #2 rst_n = 1'b1;
        repeat (5) step();
        check_val("rel_clean5", 32'(slider_clean), 32'd0);
        step();
        check_val("rel_clean6", 32'(slider_clean), 32'd7);
        check_val("rel_rise6",  32'(rise_pulse),   32'd7);
        check_val("rel_active", 32'(active_cnt),   32'd3);
        step();
        check_val("rel_press",  32'(press_cnt),    32'd1);
        check_val("rel_rise7",  32'(rise_pulse),   32'd0);

        // Settle all low.
        slider_raw = 3'b000;
        repeat (8) step();

        // Glitch of 3 cycles on ch1 is rejected, 4 cycles is accepted.
        slider_raw[1] = 1'b1;
        repeat (3) step();
        slider_raw[1] = 1'b0;
        repeat (8) step();
        check_val("glitch_clean1", 32'(slider_clean[1]), 32'd0);
        slider_raw[1] = 1'b1;
        repeat (4) step();
        slider_raw[1] = 1'b0;
        rise_at = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (fall_pulse[1] && rise_at < 0) rise_at = k;
        end
        check_val("glitch_fall_at", 32'(rise_at), 32'd6);

        // Bounce on ch0, then settle high: exactly one rise, 6 cycles later.
        for (int k = 0; k < 10; k++) begin
            slider_raw[0] = (k % 2 == 0);
            step();
        end
        slider_raw[0] = 1'b1;
        rises   = 0;
        rise_at = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (rise_pulse[0]) begin
                rises++;
                rise_at = k;
            end
        end
        check_val("bounce_rises", 32'(rises),   32'd1);
        check_val("bounce_at",    32'(rise_at), 32'd6);

        // 16 presses after a clear: reach 15, then wrap to 0.
        slider_raw[0] = 1'b0;
        repeat (8) step();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check_val("clr_press", 32'(press_cnt), 32'd0);
        for (int p = 1; p <= 16; p++) begin
            slider_raw[0] = 1'b1;
            repeat (7) step();
            slider_raw[0] = 1'b0;
            repeat (7) step();
            if (p == 15) check_val("press15", 32'(press_cnt), 32'd15);
        end
        check_val("press_wrap", 32'(press_cnt), 32'd0);

        // Clear in the same cycle as an increment wins.
        slider_raw[0] = 1'b1;
        repeat (6) step();
        check_val("pre_clr_rise", 32'(rise_pulse[0]), 32'd1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check_val("clr_wins", 32'(press_cnt), 32'd0);

        // Async reset two cycles into a pending rise on ch2.
        slider_raw = 3'b000;
        repeat (8) step();
        slider_raw[2] = 1'b1;
        repeat (4) step();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1 rst_n = 1'b1;
        repeat (5) step();
        check_val("rst_pend5", 32'(slider_clean[2]), 32'd0);
        step();
        check_val("rst_pend6", 32'(slider_clean[2]), 32'd1);

        // Simultaneous acceptance on two channels.
        slider_raw = 3'b000;
        repeat (8) step();
        slider_raw = 3'b101;
        repeat (5) step();
        check_val("sim_rise5",   32'(rise_pulse), 32'd0);
        check_val("sim_active5", 32'(active_cnt), 32'd0);
        step();
        check_val("sim_rise6",   32'(rise_pulse), 32'd5);
        check_val("sim_active6", 32'(active_cnt), 32'd2);

        // Random pin activity with occasional clears.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, (c < 300) ? 7 : 40) == 0)
                    slider_raw[i] = ~slider_raw[i];
            end
            clr_cnt = ($urandom_range(0, 19) == 0);
            step();
        end
        clr_cnt = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
